// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler beside the E-stage ALU; owns the HI/LO registers.
// Latency: MULT/MULTU busy MUL_CYCLES, DIV/DIVU busy DIV_CYCLES, MTHI/MTLO one edge, MFHI/MFLO combinational.
// Backpressure: md_stall holds a D-stage MD op while starting/busy; MD ops arriving while busy are dropped.
// Optional: define MD_SCHED_EARLY_ZERO_EN to retire zero-operand mul/div on the start edge.
module md_sched #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        md_start,
  output logic        md_stall,
  output logic [31:0] md_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] opa, opb;
  logic        op_sgn;

  logic is_mul, is_div, idle, last, fast_zero;

  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign idle   = (state == ST_IDLE);
  assign last   = (cnt == 4'd1);

`ifdef MD_SCHED_EARLY_ZERO_EN
  // Zero operands make the result trivially zero; divide-by-zero still takes the slow path.
  assign fast_zero = idle && ((is_mul && (md_a == 32'd0 || md_b == 32'd0)) ||
                              (is_div && md_a == 32'd0 && md_b != 32'd0));
`else
  assign fast_zero = 1'b0;
`endif

  // Result datapath, evaluated from the operands latched at start.
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  // Sign-extending to 64 bits makes a plain 64-bit product correct for both MULT and MULTU.
  assign a_ext = {{32{op_sgn & opa[31]}}, opa};
  assign b_ext = {{32{op_sgn & opb[31]}}, opb};
  assign prod  = a_ext * b_ext;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder takes the dividend's sign.
  // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
  assign a_neg = op_sgn & opa[31];
  assign b_neg = op_sgn & opb[31];
  assign a_mag = a_neg ? -opa : opa;
  assign b_mag = b_neg ? -opb : opb;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: leave IDLE on a slow mul/div start, return on the last busy cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (is_mul && !fast_zero)      state_nxt = ST_MUL;
        else if (is_div && !fast_zero) state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: busy from state, start/stall/read data combinational on the E-stage op.
  always_comb begin
    busy     = !idle;
    md_start = idle && (is_mul || is_div);
    md_stall = (busy || md_start) && d_md_use;
    md_rd    = 32'd0;
    if (md_op == OP_MFHI)      md_rd = hi;
    else if (md_op == OP_MFLO) md_rd = lo;
  end

  // Counter, operand latches and HI/LO; ops presented while busy are not looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 4'd0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      op_sgn <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_start && !fast_zero) begin
            opa    <= md_a;
            opb    <= md_b;
            op_sgn <= (md_op == OP_MULT) || (md_op == OP_DIV);
            cnt    <= is_mul ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
          end
          if (fast_zero) begin
            hi <= 32'd0;
            lo <= 32'd0;
          end
          if (md_op == OP_MTHI) hi <= md_a;
          if (md_op == OP_MTLO) lo <= md_a;
        end
        default: begin
          cnt <= cnt - 4'd1;
          if (last) begin
            if (state == ST_MUL) begin
              {hi, lo} <= prod;
            end else if (opb != 32'd0) begin
              hi <= rem;
              lo <= quot;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed vector bench for md_sched.
// Latency: drives on the falling edge, samples 1 time unit later.
// Backpressure: d_md_use held high so md_stall duration is observable.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        d_md_use;
  logic        busy, md_start, md_stall;
  logic [31:0] md_rd, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .d_md_use (d_md_use),
    .busy     (busy),
    .md_start (md_start),
    .md_stall (md_stall),
    .md_rd    (md_rd),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts busy and stalled cycles until busy drops, bounded.
  task automatic wait_idle(output int nb, output int ns);
    int guard;
    nb = 0;
    ns = 0;
    guard = 0;
    while (busy && guard < 40) begin
      nb++;
      if (md_stall) ns++;
      @(negedge clk); #1;
      guard++;
    end
    chk("busy_bound_expired", 32'(guard >= 40), 32'd0);
    if (md_stall) ns++;
  endtask

  // Presents one op for one cycle, then idles until busy drops.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output int ns);
    int s0;
    @(negedge clk);
    md_op = op; md_a = a; md_b = b; d_md_use = 1'b1;
    #1;
    s0 = md_stall ? 1 : 0;
    @(negedge clk);
    md_op = 4'd0;
    #1;
    wait_idle(nb, ns);
    ns += s0;
  endtask

  initial begin
    int nb, ns, exp_ns, exp_zb;

    vecs[0]  = '{4'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
    vecs[1]  = '{4'd1, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[2]  = '{4'd2, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[3]  = '{4'd3, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{4'd4, 32'h7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[7]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[8]  = '{4'd6, 32'hCAFEBABE, 32'h0,        32'hFFFFFFFE, 32'hCAFEBABE, 0};
    vecs[9]  = '{4'd3, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[10] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    // Reset state
    reset = 1'b1; md_op = 4'd0; md_a = 32'd0; md_b = 32'd0; d_md_use = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(md_stall), 32'd0);
    chk("reset_rd", md_rd, 32'd0);

    // Table of single operations
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb, ns);
      exp_ns = vecs[i].exp_busy + ((vecs[i].op >= 4'd1 && vecs[i].op <= 4'd4) ? 1 : 0);
      chk($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_stall_cycles", i), 32'(ns), 32'(exp_ns));
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      md_op = 4'd8; #1;
      chk($sformatf("v%0d_mflo", i), md_rd, vecs[i].exp_lo);
      chk($sformatf("v%0d_mflo_start", i), 32'(md_start), 32'd0);
      md_op = 4'd7; #1;
      chk($sformatf("v%0d_mfhi", i), md_rd, vecs[i].exp_hi);
      md_op = 4'd0;
    end

    // Out-of-range op behaves as NONE
    md_op = 4'd12; #1;
    chk("op12_start", 32'(md_start), 32'd0);
    chk("op12_rd", md_rd, 32'd0);
    md_op = 4'd0;

    // MTLO presented in busy cycle 2 of a MULT is ignored
    @(negedge clk); md_op = 4'd1; md_a = 32'd3; md_b = 32'd4;
    @(negedge clk); md_op = 4'd0;
    @(negedge clk); md_op = 4'd6; md_a = 32'hAAAA5555; #1;
    chk("mid_mtlo_busy", 32'(busy), 32'd1);
    @(negedge clk); md_op = 4'd0; #1;
    wait_idle(nb, ns);
    chk("mid_mtlo_rest_busy", 32'(nb), 32'd3);
    chk("mid_mtlo_lo", lo, 32'd12);
    chk("mid_mtlo_hi", hi, 32'd0);

    // Reset in busy cycle 3 of a DIV aborts it
    @(negedge clk); md_op = 4'd4; md_a = 32'd100; md_b = 32'd7;
    @(negedge clk); md_op = 4'd0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("abort_late_lo", lo, 32'd0);
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_busy", 32'(busy), 32'd0);

    // Back-to-back: second MULT on the completion edge is ignored, accepted next cycle
    @(negedge clk); md_op = 4'd1; md_a = 32'd5; md_b = 32'd6;
    @(negedge clk); md_op = 4'd0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'd1);
      @(negedge clk);
    end
    md_op = 4'd1; md_a = 32'd7; md_b = 32'd8; #1;
    chk("b2b_last_busy", 32'(busy), 32'd1);
    chk("b2b_last_start", 32'(md_start), 32'd0);
    @(negedge clk); #1;
    chk("b2b_done_busy", 32'(busy), 32'd0);
    chk("b2b_first_lo", lo, 32'd30);
    chk("b2b_restart", 32'(md_start), 32'd1);
    @(negedge clk); md_op = 4'd0; #1;
    wait_idle(nb, ns);
    chk("b2b_second_busy", 32'(nb), 32'd5);
    chk("b2b_second_lo", lo, 32'd56);
    chk("b2b_second_hi", hi, 32'd0);

    // Zero operands: fast path only when the early-zero option is built in
`ifdef MD_SCHED_EARLY_ZERO_EN
    exp_zb = 0;
`else
    exp_zb = 5;
`endif
    run_op(4'd1, 32'd9, 32'd0, nb, ns);
    chk("zmul_busy", 32'(nb), 32'(exp_zb));
    chk("zmul_stall", 32'(ns), 32'(exp_zb + 1));
    chk("zmul_hi", hi, 32'd0);
    chk("zmul_lo", lo, 32'd0);
    run_op(4'd6, 32'h55, 32'd0, nb, ns);
    run_op(4'd5, 32'h66, 32'd0, nb, ns);
`ifdef MD_SCHED_EARLY_ZERO_EN
    exp_zb = 0;
`else
    exp_zb = 10;
`endif
    run_op(4'd4, 32'd0, 32'd5, nb, ns);
    chk("zdiv_busy", 32'(nb), 32'(exp_zb));
    chk("zdiv_hi", hi, 32'd0);
    chk("zdiv_lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler for the five-stage pipeline; sits in the E stage beside the ALU.
- Accepts MD ops decoded by the control unit and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter.
- Produces the D-stage stall request the hazard logic needs while an MD operation is in flight.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  E-stage MD op encoding:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO.
  - 9..15 are treated as NONE.
- md_a  input  32  rs operand (forwarded value).
- md_b  input  32  rt operand (forwarded value).
- d_md_use  input  1  D-stage instruction is any MD op (1..8).
- busy  output  1  MD operation in flight.
- md_start  output  1  combinational; md_op is 1..4 and state is IDLE.
- md_stall  output  1  combinational; (busy | md_start) & d_md_use.
- md_rd  output  32  combinational read data:
  - HI when md_op==MFHI, LO when md_op==MFLO, else 0.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- One clock; reset is synchronous and active-high, on clk and reset.
- Reset values:
  - State IDLE, counter 0, busy 0.
  - hi 0, lo 0, internal operand latches 0.
  - md_start, md_stall and md_rd follow their combinational definitions from reset state.
  - Reset asserted mid-operation aborts the operation: HI/LO are cleared and the pending result is discarded.
- States: IDLE, MUL, DIV.
- IDLE:
  - md_op 1/2: latch operands and signedness, counter <= MUL_CYCLES, go to MUL.
  - md_op 3/4: latch operands and signedness, counter <= DIV_CYCLES, go to DIV.
  - md_op 5: hi <= md_a the same edge; no busy.
  - md_op 6: lo <= md_a the same edge; no busy.
- MUL/DIV:
  - busy=1; counter decrements each edge.
  - On the edge where counter==1: write HI/LO, return to IDLE, busy falls the same edge.
  - Latency: start at edge N → busy high for exactly N_CYCLES cycles → new HI/LO visible after edge N+N_CYCLES.
- While busy, md_op 1..6 is ignored. md_stall guarantees this never happens in legal flow; it must still not corrupt state.
- MFHI/MFLO while busy return the old HI/LO; hazard stalling prevents this in legal flow.
- Arithmetic:
  - MULT: {hi,lo} <= signed 64-bit product. MULTU: unsigned 64-bit product.
  - DIV: lo <= quotient truncated toward zero; hi <= remainder with the dividend's sign.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no trap.
  - Divide by zero: operation still runs full DIV_CYCLES and busy behaves normally; HI and LO are left unchanged.
- Simultaneous events:
  - reset has priority over everything.
  - The completion edge and a new md_op on the same edge: the new op is ignored, because state is not IDLE at that edge.
  - A new op issues next cycle at the earliest.
- md_stall asserts in the start cycle (via md_start) so a following MD instruction in D is held from that cycle on. It deasserts in the cycle after the completion edge.

Optional Feature:
- Macro MD_SCHED_EARLY_ZERO_EN.
- When defined:
  - A MULT/MULTU whose md_a or md_b is 0 at start writes hi=0, lo=0 on the start edge; no busy and the state stays IDLE.
  - A DIV/DIVU with md_a==0 and md_b!=0 writes hi=0, lo=0 on the start edge; no busy.
  - md_start still asserts for that cycle.
  - Division by zero is not fast-pathed.
- When undefined: every MULT/MULTU/DIV/DIVU takes the full parameterised latency regardless of operand values.

Test Plan:
- Reset: pulse reset 1 cycle → hi=0, lo=0, busy=0, md_stall=0. Then MTHI md_a=0x12345678 → hi=0x12345678 next edge, busy stays 0.
- MULT with md_a=0xFFFFFFFE (-2), md_b=3 and d_md_use=1 held → busy=1 for exactly 5 cycles, md_stall=1 for 6 cycles including the start cycle. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV md_a=-7 (0xFFFFFFF9), md_b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → hi/lo unchanged after 10 cycles.
- Overflow DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. MFLO then returns md_rd=0x80000000.
- Mid-op events:
  - Present MTLO 0xAAAA5555 at cycle 2 of a MULT → ignored, lo holds the product after completion.
  - Assert reset at cycle 3 of a DIV → busy=0, hi=lo=0 next edge, no later write.
- Back-to-back: MULT issued, and a second MULT presented on the completion edge → ignored. The second MULT is accepted the following cycle with a fresh 5-cycle busy. With MD_SCHED_EARLY_ZERO_EN, MULT x*0 → busy stays 0, hi=lo=0 next edge.
